// File: rtl/i2c_ioexp_target.sv
`default_nettype none
// ============================================================================
// Module   : i2c_ioexp_target
// Brief    : I2C target acting as a two-port, 8-register GPIO expander
//            (input / output / polarity / config register pairs).
//            Define I2C_IOEXP_INT_EN to add the input-change interrupt on
//            int_n; otherwise int_n is tied high.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_ioexp_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h24,
  parameter int         SYNC_STAGES = 2       // legal range 2..4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic [7:0] port0_in,
  input  logic [7:0] port1_in,
  output logic [7:0] port0_out,
  output logic [7:0] port1_out,
  output logic [7:0] port0_ddr,
  output logic [7:0] port1_ddr,
  output logic       int_n
);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_ADDR_ACK = 4'd2,
    ST_PTR      = 4'd3,
    ST_PTR_ACK  = 4'd4,
    ST_WR       = 4'd5,
    ST_WR_ACK   = 4'd6,
    ST_RD       = 4'd7,
    ST_RD_ACK   = 4'd8,
    ST_IGNORE   = 4'd9
  } state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  state_e     state_q,   state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_q,      rx_d;
  logic [6:0] tx_q,      tx_d;       // bits still to send after the one on the bus
  logic       sda_oe_q,  sda_oe_d;
  logic [2:0] ptr_q,     ptr_d;
  logic       rw_q,      rw_d;
  logic       mack_q,    mack_d;
  logic [7:0] out0_q, out0_d, out1_q, out1_d;
  logic [7:0] pol0_q, pol0_d, pol1_q, pol1_d;
  logic [7:0] cfg0_q, cfg0_d, cfg1_q, cfg1_d;
  logic [7:0] w_rd_data;

  // Bus line synchronisers plus one delayed copy for edge detection; idle-high reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= w_scl;
      sda_prev_q <= w_sda;
    end
  end

  assign w_scl      = scl_sync_q[SYNC_STAGES-1];
  assign w_sda      = sda_sync_q[SYNC_STAGES-1];
  assign w_scl_rise =  w_scl & ~scl_prev_q;
  assign w_scl_fall = ~w_scl &  scl_prev_q;
  assign w_start    =  w_scl &  scl_prev_q &  sda_prev_q & ~w_sda;
  assign w_stop     =  w_scl &  scl_prev_q & ~sda_prev_q &  w_sda;

  // Register-file read mux; input registers are the live pins with polarity applied
  always_comb begin
    w_rd_data = 8'h00;
    case (ptr_q)
      3'd0:    w_rd_data = port0_in ^ pol0_q;
      3'd1:    w_rd_data = port1_in ^ pol1_q;
      3'd2:    w_rd_data = out0_q;
      3'd3:    w_rd_data = out1_q;
      3'd4:    w_rd_data = pol0_q;
      3'd5:    w_rd_data = pol1_q;
      3'd6:    w_rd_data = cfg0_q;
      default: w_rd_data = cfg1_q;
    endcase
  end

  // Protocol FSM: next state, shift registers, SDA drive and register commits
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    sda_oe_d  = sda_oe_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    mack_d    = mack_q;
    out0_d    = out0_q;
    out1_d    = out1_q;
    pol0_d    = pol0_q;
    pol1_d    = pol1_q;
    cfg0_d    = cfg0_q;
    cfg1_d    = cfg1_q;

    if (w_stop) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
    end else if (w_start) begin
      state_d   = ST_ADDR;
      sda_oe_d  = 1'b0;
      bit_cnt_d = 4'd0;
    end else begin
      unique case (state_q)
        ST_ADDR, ST_PTR, ST_WR: begin
          if (w_scl_rise) begin
            rx_d      = {rx_q[6:0], w_sda};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (w_scl_fall && (bit_cnt_q == 4'd8)) begin
            bit_cnt_d = 4'd0;
            if (state_q == ST_ADDR) begin
              if (rx_q[7:1] == DEV_ADDR) begin
                state_d  = ST_ADDR_ACK;
                sda_oe_d = 1'b1;
                rw_d     = rx_q[0];
              end else begin
                state_d  = ST_IGNORE;
              end
            end else if (state_q == ST_PTR) begin
              ptr_d    = rx_q[2:0];
              state_d  = ST_PTR_ACK;
              sda_oe_d = 1'b1;
            end else begin
              state_d  = ST_WR_ACK;
              sda_oe_d = 1'b1;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (w_scl_fall) begin
            bit_cnt_d = 4'd0;
            if (rw_q) begin
              state_d  = ST_RD;
              tx_d     = w_rd_data[6:0];
              sda_oe_d = ~w_rd_data[7];
            end else begin
              state_d  = ST_PTR;
              sda_oe_d = 1'b0;
            end
          end
        end
        ST_PTR_ACK: begin
          if (w_scl_fall) begin
            state_d  = ST_WR;
            sda_oe_d = 1'b0;
          end
        end
        ST_WR_ACK: begin
          if (w_scl_fall) begin
            // Registers 0/1 are read-only: the byte is acknowledged but dropped
            case (ptr_q)
              3'd2:    out0_d = rx_q;
              3'd3:    out1_d = rx_q;
              3'd4:    pol0_d = rx_q;
              3'd5:    pol1_d = rx_q;
              3'd6:    cfg0_d = rx_q;
              3'd7:    cfg1_d = rx_q;
              default: ;
            endcase
            ptr_d    = {ptr_q[2:1], ~ptr_q[0]};
            state_d  = ST_WR;
            sda_oe_d = 1'b0;
          end
        end
        ST_RD: begin
          if (w_scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (w_scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d   = ST_RD_ACK;
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              ptr_d     = {ptr_q[2:1], ~ptr_q[0]};
            end else begin
              sda_oe_d = ~tx_q[6];
              tx_d     = {tx_q[5:0], 1'b0};
            end
          end
        end
        ST_RD_ACK: begin
          if (w_scl_rise) begin
            mack_d = ~w_sda;
          end else if (w_scl_fall) begin
            if (mack_q) begin
              state_d  = ST_RD;
              tx_d     = w_rd_data[6:0];
              sda_oe_d = ~w_rd_data[7];
            end else begin
              state_d  = ST_IGNORE;
              sda_oe_d = 1'b0;
            end
          end
        end
        default: ;  // IDLE and IGNORE wait for START/STOP
      endcase
    end
  end

  // State and register-file flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 4'd0;
      rx_q      <= 8'h00;
      tx_q      <= 7'h00;
      sda_oe_q  <= 1'b0;
      ptr_q     <= 3'd0;
      rw_q      <= 1'b0;
      mack_q    <= 1'b0;
      out0_q    <= 8'hFF;
      out1_q    <= 8'hFF;
      pol0_q    <= 8'h00;
      pol1_q    <= 8'h00;
      cfg0_q    <= 8'hFF;
      cfg1_q    <= 8'hFF;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      sda_oe_q  <= sda_oe_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      mack_q    <= mack_d;
      out0_q    <= out0_d;
      out1_q    <= out1_d;
      pol0_q    <= pol0_d;
      pol1_q    <= pol1_d;
      cfg0_q    <= cfg0_d;
      cfg1_q    <= cfg1_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign port0_out = out0_q;
  assign port1_out = out1_q;
  assign port0_ddr = cfg0_q;
  assign port1_ddr = cfg1_q;

`ifdef I2C_IOEXP_INT_EN
  logic [7:0] p0_meta_q, p0_sync_q, p1_meta_q, p1_sync_q;
  logic [7:0] snap0_q, snap1_q, pend_q;
  logic       int_n_q;
  logic       w_rd_load, w_rd_done, w_in_reg;

  // A read of an input register captures the pins at load and adopts them as
  // the new reference when the byte's ACK slot begins
  assign w_in_reg  = (ptr_q[2:1] == 2'b00);
  assign w_rd_load = w_scl_fall & (((state_q == ST_ADDR_ACK) & rw_q) |
                                   ((state_q == ST_RD_ACK) & mack_q));
  assign w_rd_done = w_scl_fall & (state_q == ST_RD) & (bit_cnt_q == 4'd8);

  // Pin synchronisers, last-read snapshots and registered change detector
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p0_meta_q <= 8'h00;
      p0_sync_q <= 8'h00;
      p1_meta_q <= 8'h00;
      p1_sync_q <= 8'h00;
      snap0_q   <= 8'h00;
      snap1_q   <= 8'h00;
      pend_q    <= 8'h00;
      int_n_q   <= 1'b1;
    end else begin
      p0_meta_q <= port0_in;
      p0_sync_q <= p0_meta_q;
      p1_meta_q <= port1_in;
      p1_sync_q <= p1_meta_q;
      if (w_rd_load && w_in_reg) begin
        pend_q <= ptr_q[0] ? p1_sync_q : p0_sync_q;
      end
      if (w_rd_done && w_in_reg) begin
        if (ptr_q[0]) snap1_q <= pend_q;
        else          snap0_q <= pend_q;
      end
      int_n_q <= ~(|(((p0_sync_q ^ snap0_q) & cfg0_q) | ((p1_sync_q ^ snap1_q) & cfg1_q)));
    end
  end

  assign int_n = int_n_q;
`else
  assign int_n = 1'b1;
`endif

endmodule
`default_nettype wire
